// File: rtl/sccb_write_arbiter.sv
// Two-requester arbiter in front of an SCCB register-write engine.
// Round-robin grant, bounded retries on NACK/timeout, enforced idle gap after
// every transaction (longer after a soft-reset write), one done per request.
module sccb_write_arbiter #(
  parameter logic [7:0]  SLAVE_ID       = 8'h42,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned RST_GAP_CYCLES = 1500000,
  parameter logic [7:0]  RST_REG        = 8'h12,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_done,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       req1_err,
  output logic       eng_start,
  output logic [7:0] eng_slave,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_data,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic       eng_nack,
  output logic       busy,
  output logic       grant
);

  localparam int unsigned GAP_MAX = (RST_GAP_CYCLES > GAP_CYCLES) ? RST_GAP_CYCLES : GAP_CYCLES;
  localparam int unsigned GAP_W   = ($clog2(GAP_MAX) > 0) ? $clog2(GAP_MAX) : 1;
  localparam int unsigned TO_W    = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RT_W    = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Gap counter holds remaining-cycles-minus-one so the largest gap fits in $clog2 bits.
  localparam logic [GAP_W-1:0] GAP_LOAD     = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] RST_GAP_LOAD = GAP_W'(RST_GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LOAD      = TO_W'(TIMEOUT_CYCLES);
  localparam logic [RT_W-1:0]  RT_MAX       = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, REPORT} state_t;

  state_t           state, state_nxt;
  logic             last_served, last_d;
  logic             retry_pend, pend_d;
  logic             err_flag, errf_d;
  logic [RT_W-1:0]  retry_cnt, retry_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic [TO_W-1:0]  to_cnt, to_d;
  logic [7:0]       addr_d, data_d;
  logic             grant_d, sel, fail;
  logic             rdy0_d, rdy1_d, done0_d, done1_d, err0_d, err1_d, start_d, busy_d;

  assign eng_slave = SLAVE_ID;

  // Register state, datapath and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      retry_pend  <= 1'b0;
      err_flag    <= 1'b0;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      eng_addr    <= '0;
      eng_data    <= '0;
      grant       <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_d;
      retry_pend  <= pend_d;
      err_flag    <= errf_d;
      retry_cnt   <= retry_d;
      gap_cnt     <= gap_d;
      to_cnt      <= to_d;
      eng_addr    <= addr_d;
      eng_data    <= data_d;
      grant       <= grant_d;
      req0_ready  <= rdy0_d;
      req1_ready  <= rdy1_d;
      req0_done   <= done0_d;
      req1_done   <= done1_d;
      req0_err    <= err0_d;
      req1_err    <= err1_d;
      eng_start   <= start_d;
      busy        <= busy_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_nxt = ISSUE;
      ISSUE:   if (!eng_busy) state_nxt = WAIT;
      WAIT:    if (eng_done || (to_cnt <= TO_W'(1))) state_nxt = GAP;
      GAP:     if (gap_cnt == '0) state_nxt = retry_pend ? ISSUE : REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of datapath and outputs; pulses are raised on entry to the
  // state they belong to so the registered copy lines up with that state.
  always_comb begin
    last_d  = last_served;
    pend_d  = retry_pend;
    errf_d  = err_flag;
    retry_d = retry_cnt;
    gap_d   = gap_cnt;
    to_d    = to_cnt;
    addr_d  = eng_addr;
    data_d  = eng_data;
    grant_d = grant;
    sel     = 1'b0;
    fail    = 1'b0;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    start_d = 1'b0;
    busy_d  = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          sel     = (req0_valid && req1_valid) ? ~last_served : req1_valid;
          grant_d = sel;
          addr_d  = sel ? req1_addr : req0_addr;
          data_d  = sel ? req1_data : req0_data;
          rdy0_d  = ~sel;
          rdy1_d  = sel;
          retry_d = '0;
          pend_d  = 1'b0;
          errf_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (!eng_busy) begin
          start_d = 1'b1;
          to_d    = TO_LOAD;
        end
      end
      WAIT: begin
        // A completion in the same cycle as timeout expiry wins.
        if (eng_done) begin
          if (eng_nack) begin
            fail = 1'b1;
          end else begin
            pend_d = 1'b0;
            errf_d = 1'b0;
            gap_d  = ((eng_addr == RST_REG) && eng_data[7]) ? RST_GAP_LOAD : GAP_LOAD;
          end
        end else if (to_cnt <= TO_W'(1)) begin
          fail = 1'b1;
        end else begin
          to_d = to_cnt - 1'b1;
        end
        if (fail) begin
          gap_d = GAP_LOAD;
          if (retry_cnt < RT_MAX) begin
            retry_d = retry_cnt + 1'b1;
            pend_d  = 1'b1;
          end else begin
            pend_d = 1'b0;
            errf_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_d = gap_cnt - 1'b1;
        end else if (!retry_pend) begin
          done0_d = ~grant;
          done1_d = grant;
          err0_d  = ~grant & err_flag;
          err1_d  = grant & err_flag;
        end
      end
      REPORT: last_d = grant;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter with shortened gap/timeout lengths.
module tb_sccb_write_arbiter;

  localparam int GAP_C     = 8;
  localparam int RST_GAP_C = 40;
  localparam int TO_C      = 20;
  // Cycles from an eng_start sample to the engine's eng_done sample.
  localparam int ENG_LAT   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_addr = '0, req0_data = '0, req1_addr = '0, req1_data = '0;
  logic       req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic       eng_start, busy, grant;
  logic [7:0] eng_slave, eng_addr, eng_data;
  logic       eng_busy = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;

  logic       z_req0_valid = 1'b0;
  logic [7:0] z_req0_addr = 8'h5A, z_req0_data = 8'hA5;
  logic       z_req0_ready, z_req0_done, z_req0_err, z_req1_ready, z_req1_done, z_req1_err;
  logic       z_eng_start, z_busy, z_grant;
  logic [7:0] z_eng_slave, z_eng_addr, z_eng_data;
  logic       z_eng_done = 1'b0, z_eng_nack = 1'b0;

  sccb_write_arbiter #(
    .SLAVE_ID(8'h42), .MAX_RETRY(3), .GAP_CYCLES(GAP_C), .RST_GAP_CYCLES(RST_GAP_C),
    .RST_REG(8'h12), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .eng_start(eng_start), .eng_slave(eng_slave), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
    .busy(busy), .grant(grant)
  );

  sccb_write_arbiter #(
    .SLAVE_ID(8'h42), .MAX_RETRY(0), .GAP_CYCLES(GAP_C), .RST_GAP_CYCLES(RST_GAP_C),
    .RST_REG(8'h12), .TIMEOUT_CYCLES(TO_C)
  ) dut_z (
    .clk(clk), .reset(reset),
    .req0_valid(z_req0_valid), .req0_addr(z_req0_addr), .req0_data(z_req0_data),
    .req0_ready(z_req0_ready), .req0_done(z_req0_done), .req0_err(z_req0_err),
    .req1_valid(1'b0), .req1_addr(8'h00), .req1_data(8'h00),
    .req1_ready(z_req1_ready), .req1_done(z_req1_done), .req1_err(z_req1_err),
    .eng_start(z_eng_start), .eng_slave(z_eng_slave), .eng_addr(z_eng_addr), .eng_data(z_eng_data),
    .eng_busy(1'b0), .eng_done(z_eng_done), .eng_nack(z_eng_nack),
    .busy(z_busy), .grant(z_grant)
  );

  // Engine model: busy for a few cycles after start, then done. The first
  // attempts up to fail_target fail (NACK, or silence when fail_silent).
  int  fail_target = 0;
  bit  fail_silent = 1'b0;
  int  e_fails = 0;
  bit  e_pend = 1'b0;
  int  e_lat = 0;
  always @(negedge clk) begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (e_pend) begin
      if (e_lat == 0) begin
        e_pend   = 1'b0;
        eng_busy = 1'b0;
        if (e_fails < fail_target) begin
          e_fails++;
          if (!fail_silent) begin
            eng_done = 1'b1;
            eng_nack = 1'b1;
          end
        end else begin
          eng_done = 1'b1;
        end
      end else begin
        e_lat--;
      end
    end else if (eng_start) begin
      e_pend   = 1'b1;
      eng_busy = 1'b1;
      e_lat    = 3;
    end
  end

  // Engine for the no-retry instance: always NACKs one cycle after start.
  logic z_dly = 1'b0;
  always @(negedge clk) begin
    z_eng_done = z_dly;
    z_eng_nack = z_dly;
    z_dly      = z_eng_start;
  end

  // Event recorder sampled just after each rising edge.
  int         cyc = 0, n_start = 0, n_done = 0, n_overlap = 0, n_dual = 0;
  int         edone_cyc = 0, done_cyc = 0, done_who = 0, done_err = 0;
  int         st_cyc[$], rdy_q[$];
  logic [7:0] st_addr[$], st_data[$];
  int         z_starts = 0, z_dones = 0, z_err = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (eng_start) begin
      n_start++;
      st_cyc.push_back(cyc);
      st_addr.push_back(eng_addr);
      st_data.push_back(eng_data);
      if (eng_busy) n_overlap++;
    end
    if (eng_done) edone_cyc = cyc;
    if (req0_ready && req1_ready) n_dual++;
    else if (req0_ready) rdy_q.push_back(0);
    else if (req1_ready) rdy_q.push_back(1);
    if (req0_done || req1_done) begin
      n_done++;
      done_cyc = cyc;
      done_who = req1_done ? 1 : 0;
      done_err = req1_done ? int'(req1_err) : int'(req0_err);
    end
    if (z_eng_start) z_starts++;
    if (z_req0_done) begin
      z_dones++;
      z_err = int'(z_req0_err);
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int who, input logic [7:0] a, input logic [7:0] d, output bit ok);
    @(negedge clk);
    if (who == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    else          begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    // Scramble the bus afterwards: the arbiter must have latched already.
    if (who == 0) begin req0_valid = 1'b0; req0_addr = 8'hEE; req0_data = 8'hEE; end
    else          begin req1_valid = 1'b0; req1_addr = 8'hEE; req1_data = 8'hEE; end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err, eng_start} !== 7'b0)
      $display("FAIL reset_pulses: got %b want 0000000", {req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err, eng_start});
    else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", grant); else n_pass++;
    n_chk++; if ({eng_addr, eng_data} !== 16'h0000) $display("FAIL reset_addr_data: got %h want 0000", {eng_addr, eng_data}); else n_pass++;
    n_chk++; if (eng_slave !== 8'h42) $display("FAIL slave_id: got %h want 42", eng_slave); else n_pass++;
  endtask

  task automatic test_single_write();
    bit ok;
    int sb, rb, nb;
    sb = st_cyc.size(); rb = rdy_q.size(); nb = n_done;
    fail_target = e_fails;
    send(0, 8'h11, 8'hF0, ok);
    n_chk++; if (!ok) $display("FAIL single_ready: got no ready want ready within 100 cycles"); else n_pass++;
    wait_done(nb + 1, 200, ok);
    n_chk++; if (!ok) $display("FAIL single_done: got no done want done within 200 cycles"); else n_pass++;
    n_chk++; if (st_cyc.size() - sb !== 1) $display("FAIL single_starts: got %0d want 1", st_cyc.size() - sb); else n_pass++;
    n_chk++; if ({st_addr[sb], st_data[sb]} !== 16'h11F0) $display("FAIL single_addr_data: got %h want 11f0", {st_addr[sb], st_data[sb]}); else n_pass++;
    n_chk++; if (rdy_q.size() - rb !== 1 || rdy_q[rb] !== 0) $display("FAIL single_ready_count: got %0d want 1 on req0", rdy_q.size() - rb); else n_pass++;
    n_chk++; if (done_cyc - edone_cyc !== GAP_C) $display("FAIL single_gap: got %0d want %0d", done_cyc - edone_cyc, GAP_C); else n_pass++;
    n_chk++; if (done_who !== 0 || done_err !== 0) $display("FAIL single_done_err: got who %0d err %0d want who 0 err 0", done_who, done_err); else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || grant !== 1'b0) $display("FAIL single_idle: got busy %b grant %b want 0 0", busy, grant); else n_pass++;
  endtask

  task automatic test_contention();
    bit ok;
    int sb, rb, nb;
    do_reset();
    sb = st_cyc.size(); rb = rdy_q.size(); nb = n_done;
    fail_target = e_fails;
    req0_addr = 8'h20; req0_data = 8'h01; req1_addr = 8'h30; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy_q.size() - rb >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_chk++; if (!ok) $display("FAIL contention_readies: got %0d want 4", rdy_q.size() - rb); else n_pass++;
    wait_done(nb + 4, 300, ok);
    n_chk++; if (!ok) $display("FAIL contention_done: got %0d want 4", n_done - nb); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (rdy_q[rb + i] !== i % 2) $display("FAIL contention_grant%0d: got %0d want %0d", i, rdy_q[rb + i], i % 2); else n_pass++;
      n_chk++; if (st_addr[sb + i] !== ((i % 2) ? 8'h30 : 8'h20))
        $display("FAIL contention_addr%0d: got %h want %h", i, st_addr[sb + i], (i % 2) ? 8'h30 : 8'h20);
      else n_pass++;
    end
    n_chk++; if (n_overlap !== 0 || n_dual !== 0) $display("FAIL contention_overlap: got %0d/%0d want 0/0", n_overlap, n_dual); else n_pass++;
  endtask

  task automatic test_nack_retry();
    bit ok;
    int sb, nb;
    sb = st_cyc.size(); nb = n_done;
    fail_silent = 1'b0;
    fail_target = e_fails + 2;
    send(1, 8'h44, 8'h55, ok);
    wait_done(nb + 1, 300, ok);
    n_chk++; if (!ok) $display("FAIL nack_done: got no done want done within 300 cycles"); else n_pass++;
    n_chk++; if (st_cyc.size() - sb !== 3) $display("FAIL nack_starts: got %0d want 3", st_cyc.size() - sb); else n_pass++;
    n_chk++; if (st_cyc[sb + 1] - st_cyc[sb] !== ENG_LAT + GAP_C + 1)
      $display("FAIL nack_spacing: got %0d want %0d", st_cyc[sb + 1] - st_cyc[sb], ENG_LAT + GAP_C + 1);
    else n_pass++;
    n_chk++; if (done_who !== 1 || done_err !== 0) $display("FAIL nack_done_err: got who %0d err %0d want who 1 err 0", done_who, done_err); else n_pass++;
  endtask

  task automatic test_exhausted();
    bit ok;
    int sb, nb;
    sb = st_cyc.size(); nb = n_done;
    fail_silent = 1'b0;
    fail_target = e_fails + 4;
    send(0, 8'h45, 8'h56, ok);
    wait_done(nb + 1, 400, ok);
    n_chk++; if (!ok) $display("FAIL exhaust_done: got no done want done within 400 cycles"); else n_pass++;
    n_chk++; if (st_cyc.size() - sb !== 4) $display("FAIL exhaust_starts: got %0d want 4", st_cyc.size() - sb); else n_pass++;
    n_chk++; if (done_who !== 0 || done_err !== 1) $display("FAIL exhaust_err: got who %0d err %0d want who 0 err 1", done_who, done_err); else n_pass++;
    n_chk++; if (n_done - nb !== 1) $display("FAIL exhaust_done_count: got %0d want 1", n_done - nb); else n_pass++;
  endtask

  task automatic test_soft_reset_timeout();
    bit ok;
    int sb, nb;
    nb = n_done;
    fail_target = e_fails;
    send(0, 8'h12, 8'h80, ok);
    wait_done(nb + 1, 300, ok);
    n_chk++; if (done_cyc - edone_cyc !== RST_GAP_C) $display("FAIL softrst_gap: got %0d want %0d", done_cyc - edone_cyc, RST_GAP_C); else n_pass++;
    send(0, 8'h12, 8'h7F, ok);
    wait_done(nb + 2, 300, ok);
    n_chk++; if (done_cyc - edone_cyc !== GAP_C) $display("FAIL bit7_clear_gap: got %0d want %0d", done_cyc - edone_cyc, GAP_C); else n_pass++;
    sb = st_cyc.size();
    fail_silent = 1'b1;
    fail_target = e_fails + 1;
    send(1, 8'h66, 8'h77, ok);
    wait_done(nb + 3, 300, ok);
    fail_silent = 1'b0;
    n_chk++; if (!ok) $display("FAIL timeout_done: got no done want done within 300 cycles"); else n_pass++;
    n_chk++; if (st_cyc.size() - sb !== 2) $display("FAIL timeout_starts: got %0d want 2", st_cyc.size() - sb); else n_pass++;
    n_chk++; if (st_cyc[sb + 1] - st_cyc[sb] !== TO_C + GAP_C + 1)
      $display("FAIL timeout_spacing: got %0d want %0d", st_cyc[sb + 1] - st_cyc[sb], TO_C + GAP_C + 1);
    else n_pass++;
    n_chk++; if (done_who !== 1 || done_err !== 0) $display("FAIL timeout_err: got who %0d err %0d want who 1 err 0", done_who, done_err); else n_pass++;
  endtask

  task automatic test_no_retry();
    bit ok;
    int zs, zd;
    zs = z_starts; zd = z_dones;
    @(negedge clk);
    z_req0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (z_req0_ready) begin ok = 1'b1; break; end
    end
    z_req0_valid = 1'b0;
    for (int i = 0; i < 100 && z_dones == zd; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_chk++; if (z_starts - zs !== 1) $display("FAIL noretry_starts: got %0d want 1", z_starts - zs); else n_pass++;
    n_chk++; if (z_dones - zd !== 1 || z_err !== 1) $display("FAIL noretry_done: got dones %0d err %0d want 1 1", z_dones - zd, z_err); else n_pass++;
  endtask

  task automatic test_mid_wait_reset();
    bit ok;
    int sbase, nb;
    sbase = n_start; nb = n_done;
    fail_target = e_fails;
    send(0, 8'h21, 8'h22, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_start > sbase) begin ok = 1'b1; break; end
    end
    n_chk++; if (!ok) $display("FAIL midwait_start: got no start want start within 50 cycles"); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; if (n_done !== nb) $display("FAIL midwait_no_done: got %0d dones want 0", n_done - nb); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL midwait_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (n_start - sbase !== 1) $display("FAIL midwait_restart: got %0d starts want 1", n_start - sbase); else n_pass++;
    n_chk++; if ({grant, eng_addr} !== 9'h000) $display("FAIL midwait_cleared: got %h want 000", {grant, eng_addr}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_nack_retry();
    test_exhausted();
    test_soft_reset_timeout();
    test_no_retry();
    test_mid_wait_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want finished by 400000");
    $fatal(1);
  end

endmodule

// File: doc/sccb_write_arbiter.md
SCCB_WRITE_ARBITER -- requirements
Module: sccb_write_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SLAVE_ID, 8'h42, SCCB write ID driven on eng_slave.
- MAX_RETRY, 3, re-issues allowed after NACK or timeout.
- GAP_CYCLES, 1000, idle cycles after every transaction.
- RST_GAP_CYCLES, 1500000, idle cycles after a soft-reset write.
- RST_REG, 8'h12, register whose bit 7 = 1 is a soft reset.
- TIMEOUT_CYCLES, 100000, maximum WAIT cycles before the engine is declared hung.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock. reset is synchronous and active-high.
- reset, in, 1, synchronous active-high reset.
- req0_valid, in, 1, requester 0 write request.
- req0_addr, in, 8, register address.
- req0_data, in, 8, register data.
- req0_ready, out, 1, one-cycle accept pulse.
- req0_done, out, 1, one-cycle completion pulse.
- req0_err, out, 1, failure flag; valid only while req0_done is high.
- req1_valid, req1_addr, req1_data, req1_ready, req1_done, req1_err: same as requester 0, for requester 1.
- eng_start, out, 1, one-cycle start pulse to the SCCB write engine.
- eng_slave, out, 8, slave ID to the engine.
- eng_addr, out, 8, register address to the engine.
- eng_data, out, 8, register data to the engine.
- eng_busy, in, 1, engine busy.
- eng_done, in, 1, engine completion pulse.
- eng_nack, in, 1, engine NACK; sampled only when eng_done is high.
- busy, out, 1, high in every state except IDLE.
- grant, out, 1, index of the owning requester; holds its last value while in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, GAP and REPORT; all outputs SHALL be registered.
REQ-004 In IDLE, when any reqN_valid is high, the block SHALL:
- select a requester;
- latch its addr/data into eng_addr/eng_data;
- set grant;
- pulse the selected reqN_ready for one cycle;
- clear the retry counter;
- go to ISSUE on the next cycle.
REQ-005 Arbitration SHALL be round-robin: when both requesters are valid, the requester not served last wins; after reset, last-served SHALL be 1, so requester 0 wins first.
REQ-006 A requester SHALL hold valid, addr and data stable until it receives ready; the block SHALL ignore reqN_addr/reqN_data at every other time.
REQ-007 In ISSUE, eng_start SHALL pulse for exactly one cycle on the first cycle eng_busy is low; the block SHALL then go to WAIT and load the timeout counter.
REQ-008 In WAIT, eng_done with eng_nack = 0 SHALL be a success.
REQ-009 In WAIT, the following SHALL each be a failure attempt:
- eng_done with eng_nack = 1;
- TIMEOUT_CYCLES elapsing without eng_done.
REQ-010 On a failure attempt with retry count < MAX_RETRY, the block SHALL increment the retry count and enter GAP with a retry-pending flag set.
REQ-011 On a failure attempt with retry count == MAX_RETRY, the block SHALL set the error flag and enter GAP.
REQ-012 The GAP length SHALL be RST_GAP_CYCLES when the transaction succeeded, eng_addr == RST_REG and eng_data[7] == 1; otherwise it SHALL be GAP_CYCLES.
REQ-013 GAP SHALL last exactly its loaded cycle count; it SHALL then go to ISSUE if a retry is pending, else to REPORT.
REQ-014 REPORT SHALL last one cycle: pulse the granted reqN_done, drive reqN_err = error flag, update last-served, return to IDLE.
REQ-015 Total attempts per request SHALL be at most MAX_RETRY+1; exactly one done pulse SHALL be produced per accepted request.
REQ-016 eng_done and eng_nack SHALL be ignored outside WAIT; eng_done arriving in the same cycle the timeout expires SHALL take priority over the timeout.
REQ-017 The counters SHALL be sized as follows:
- gap counter: $clog2 of the maximum of RST_GAP_CYCLES and GAP_CYCLES;
- timeout counter: $clog2(TIMEOUT_CYCLES+1);
- retry counter: $clog2(MAX_RETRY+1).
REQ-018 MAX_RETRY = 0 SHALL produce exactly one attempt with no retry.
REQ-019 A request arriving while busy SHALL remain pending and SHALL be arbitrated in the first IDLE cycle.
REQ-020 eng_slave SHALL be constant SLAVE_ID.

Reset
REQ-021 On synchronous reset, the block SHALL:
- set state to IDLE;
- drive all ready, done, err and eng_start outputs low;
- clear busy;
- set grant = 0 and last-served = 1;
- clear all counters;
- clear eng_addr and eng_data to 0.
REQ-022 Reset in any state SHALL take effect on the next clock edge, emit no done pulse, and discard any in-flight engine result.

Verification
REQ-023 Single write: req0 addr = 8'h11, data = 8'hF0; the engine acks. Required response:
- one req0_ready;
- one eng_start with eng_addr = 11, eng_data = F0;
- GAP of 1000 cycles;
- req0_done with req0_err = 0.
REQ-024 Contention: req0 and req1 both valid from reset, held valid. Required response: grants alternate 0,1,0,1; no overlapping eng_start pulses.
REQ-025 NACK retry: the engine NACKs twice, then acks. Required response: 3 eng_start pulses separated by GAP, then done with err = 0.
REQ-026 Exhausted retries: the engine always NACKs. Required response: 4 eng_start pulses, then done with err = 1.
REQ-027 Soft reset and timeout: write addr = 12, data = 80 with the engine acking; then a second write with eng_done never asserted. Required response:
- 1,500,000-cycle GAP after the first write;
- timeout after 100000 cycles on the second write, counted as one failure attempt.
REQ-028 Reset mid-WAIT: assert reset, then eng_done arrives. Required response: IDLE, busy = 0, no done pulse.
